// File: rtl/kyber_coef_reader.sv
// Read sequencer for the 128x48 coefficient RAM: issues port-B reads and unpacks words into 12-bit lanes.
// Optional macro KYBER_COEF_REDUCE_EN applies a single conditional subtraction of q=3329 to each output lane.
module kyber_coef_reader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 48,
  parameter int COEF_W = 12
) (
  input  logic              clkb,
  input  logic              resetb,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic              ram_ceb,
  output logic              ram_oce,
  output logic [ADDR_W-1:0] ram_adb,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [COEF_W-1:0] coef_data,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              coef_last
);

  localparam int COEFS  = DATA_W / COEF_W;
  localparam int LANE_W = $clog2(COEFS);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(COEFS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W:0]    num_q, issued, popped;
  logic               inflight;
  logic [DATA_W-1:0]  fifo_mem [2];
  logic               wr_ptr, rd_ptr;
  logic [1:0]         fifo_count;
  logic [LANE_W-1:0]  lane;
  logic               fetch, hs, pop, last_word;
  logic [COEF_W-1:0]  lane_raw, lane_out;

  assign ram_oce = 1'b1;

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    done       = (state == FIN);
    // Outstanding words (buffered + in flight) may never exceed the 2-deep FIFO.
    fetch      = (state == RUN) && (issued < num_q) &&
                 (({1'b0, fifo_count} + 3'(inflight)) < 3'd2);
    ram_ceb    = fetch;
    coef_valid = (fifo_count != 2'd0);
    hs         = coef_valid && coef_ready;
    pop        = hs && (lane == LAST_LANE);
    last_word  = (popped == num_q - 1'b1);
    coef_last  = coef_valid && (lane == LAST_LANE) && last_word;
    lane_raw   = fifo_mem[rd_ptr][lane*COEF_W +: COEF_W];
`ifdef KYBER_COEF_REDUCE_EN
    lane_out   = (lane_raw >= COEF_W'(3329)) ? lane_raw - COEF_W'(3329) : lane_raw;
`else
    lane_out   = lane_raw;
`endif
    coef_data  = coef_valid ? lane_out : '0;
    case (state)
      IDLE: if (start) state_nxt = (num_words == '0) ? FIN : RUN;
      RUN:  if (hs && coef_last) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkb) begin
    if (resetb) begin
      state      <= IDLE;
      num_q      <= '0;
      issued     <= '0;
      popped     <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
      lane       <= '0;
      ram_adb    <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fetch;
      if (state == IDLE && start) begin
        num_q   <= num_words;
        ram_adb <= base_addr;
        issued  <= '0;
        popped  <= '0;
        lane    <= '0;
      end
      if (fetch) begin
        ram_adb <= ram_adb + 1'b1;
        issued  <= issued + 1'b1;
      end
      if (inflight) wr_ptr <= ~wr_ptr;
      if (hs) lane <= lane + 1'b1;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        popped <= popped + 1'b1;
      end
      case ({inflight, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Read data lands one cycle after the issue, so the in-flight flag is the write strobe.
  always_ff @(posedge clkb) begin
    if (!resetb && inflight) fifo_mem[wr_ptr] <= ram_dout;
  end

endmodule

// File: tb/tb_kyber_coef_reader.sv
// Scoreboard bench for kyber_coef_reader: stimulus queues expected lanes/addresses, a negedge monitor checks them.
module tb_kyber_coef_reader;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 48;
  localparam int COEF_W = 12;

  logic              clkb = 1'b0;
  logic              resetb, start, coef_ready;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_words;
  logic              busy, done, ram_ceb, ram_oce, coef_valid, coef_last;
  logic [ADDR_W-1:0] ram_adb;
  logic [DATA_W-1:0] ram_dout;
  logic [COEF_W-1:0] coef_data;

  always #5 clkb = ~clkb;

  kyber_coef_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
    .clkb(clkb), .resetb(resetb), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .ram_ceb(ram_ceb),
    .ram_oce(ram_oce), .ram_adb(ram_adb), .ram_dout(ram_dout),
    .coef_data(coef_data), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_last(coef_last)
  );

  logic [DATA_W-1:0] mem [128];
  always @(posedge clkb) if (ram_ceb) ram_dout <= mem[ram_adb];

  int checks = 0;
  int errors = 0;
  logic [COEF_W:0]   exp_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  int outstanding = 0;
  int lane_m = 0;
  int hs_run = 0;
  bit zero_run = 0;
  bit exp_done = 0;
  bit prev_stall = 0;
  logic [COEF_W-1:0] prev_data;
  logic prev_last;
  bit bp_on = 0;
  int bp_idx = 0;
  bit bp_pat [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask

  always @(negedge clkb) begin
    if (resetb) begin
      exp_q.delete();
      addr_q.delete();
      outstanding = 0;
      lane_m = 0;
      exp_done = 0;
      prev_stall = 0;
    end else begin
      if (ram_ceb) begin
        if (addr_q.size() == 0) fail("spurious_read");
        else chk("ram_adb", ram_adb, addr_q.pop_front());
        chk("fetch_ahead", outstanding < 2, 1);
        outstanding++;
      end
      if (!zero_run && (done || exp_done)) chk("done_pulse", done, exp_done);
      exp_done = 0;
      if (prev_stall) begin
        chk("stall_valid", coef_valid, 1);
        chk("stall_data", coef_data, prev_data);
        chk("stall_last", coef_last, prev_last);
      end
      if (coef_valid && coef_ready) begin
        if (exp_q.size() == 0) fail("extra_coef");
        else begin
          logic [COEF_W:0] e;
          e = exp_q.pop_front();
          chk("coef_data", coef_data, e[COEF_W-1:0]);
          chk("coef_last", coef_last, e[COEF_W]);
          exp_done = e[COEF_W];
        end
        if (lane_m == 3) outstanding--;
        lane_m = (lane_m + 1) % 4;
        hs_run++;
      end
      prev_stall = coef_valid && !coef_ready;
      prev_data  = coef_data;
      prev_last  = coef_last;
    end
  end

  initial forever begin
    @(posedge clkb);
    #1;
    if (bp_on) begin
      coef_ready = bp_pat[bp_idx];
      if (bp_idx < 31) bp_idx++;
    end
  end

  function automatic logic [COEF_W-1:0] model_lane(input logic [COEF_W-1:0] c);
`ifdef KYBER_COEF_REDUCE_EN
    return (c >= 12'd3329) ? c - 12'd3329 : c;
`else
    return c;
`endif
  endfunction

  task automatic cyc();
    @(posedge clkb);
    #1;
  endtask

  task automatic push_run(input int base, input int n);
    for (int w = 0; w < n; w++) begin
      logic [DATA_W-1:0] word;
      word = mem[(base + w) % 128];
      addr_q.push_back(ADDR_W'((base + w) % 128));
      for (int k = 0; k < 4; k++)
        exp_q.push_back({(w == n - 1) && (k == 3), model_lane(word[k*COEF_W +: COEF_W])});
    end
  endtask

  task automatic start_only(input int base, input int n);
    hs_run    = 0;
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    num_words = (ADDR_W+1)'(n);
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      if (!busy && exp_q.size() == 0) break;
      cyc();
    end
    if (k == 400) fail(name);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_ceb"}, ram_ceb, 0);
    chk({name, "_adb"}, ram_adb, 0);
    chk({name, "_valid"}, coef_valid, 0);
    chk({name, "_last"}, coef_last, 0);
    chk({name, "_data"}, coef_data, 0);
    chk({name, "_oce"}, ram_oce, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    resetb = 1'b1; start = 1'b0; coef_ready = 1'b1; base_addr = '0; num_words = '0;
    for (int i = 0; i < 128; i++)
      for (int k = 0; k < 4; k++) mem[i][k*COEF_W +: COEF_W] = COEF_W'(i * 16 + k + 1);
    mem[5]  = 48'h00C00B00A009;
    mem[6]  = 48'h01000F00E00D;
    mem[40] = 48'h000FFFD01D00;
    for (int i = 0; i < 32; i++) bp_pat[i] = 1'b1;
    bp_pat[5] = 0; bp_pat[6] = 0;
    for (int i = 8; i < 18; i++) bp_pat[i] = 0;
    bp_pat[19] = 0; bp_pat[21] = 0;
    repeat (3) cyc();
    chk_reset_outputs("reset");
    resetb = 1'b0;
    cyc();

    // basic run with hand-written lanes
    addr_q.push_back(7'd5); addr_q.push_back(7'd6);
    exp_q.push_back(13'h0009); exp_q.push_back(13'h000A);
    exp_q.push_back(13'h000B); exp_q.push_back(13'h000C);
    exp_q.push_back(13'h000D); exp_q.push_back(13'h000E);
    exp_q.push_back(13'h000F); exp_q.push_back(13'h1010);
    start_only(5, 2);
    chk("basic_c1_ceb", ram_ceb, 1);
    chk("basic_c1_busy", busy, 1);
    cyc();
    chk("basic_c2_ceb", ram_ceb, 1);
    chk("basic_c2_valid", coef_valid, 0);
    cyc();
    chk("basic_c3_valid", coef_valid, 1);
    chk("basic_c3_data", coef_data, 12'h009);
    wait_idle("basic_timeout");
    chk("basic_count", hs_run, 8);

    // backpressure
    bp_idx = 0; bp_on = 1;
    push_run(20, 4);
    start_only(20, 4);
    wait_idle("bp_timeout");
    bp_on = 0; coef_ready = 1'b1;
    chk("bp_count", hs_run, 16);

    // address wrap
    push_run(126, 4);
    start_only(126, 4);
    wait_idle("wrap_timeout");
    chk("wrap_count", hs_run, 16);

    // zero-length run
    zero_run = 1;
    start_only(0, 0);
    chk("zero_busy1", busy, 1);
    chk("zero_done1", done, 1);
    chk("zero_ceb1", ram_ceb, 0);
    cyc();
    chk("zero_busy2", busy, 0);
    chk("zero_done2", done, 0);
    zero_run = 0;
    cyc();

    // start during a run is ignored
    push_run(30, 3);
    start_only(30, 3);
    repeat (4) cyc();
    start = 1'b1; base_addr = 7'd90; num_words = 8'd5;
    cyc();
    start = 1'b0;
    wait_idle("ignore_timeout");
    repeat (10) cyc();
    chk("ignore_valid", coef_valid, 0);
    chk("ignore_busy", busy, 0);
    chk("ignore_count", hs_run, 12);

    // reset in the middle of a run
    push_run(60, 4);
    start_only(60, 4);
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        if (hs_run >= 5) break;
        cyc();
      end
      if (k == 100) fail("rst_wait_timeout");
    end
    resetb = 1'b1;
    cyc();
    resetb = 1'b0;
    chk_reset_outputs("midrst");
    cyc();
    push_run(0, 1);
    start_only(0, 1);
    wait_idle("post_rst_timeout");
    chk("post_rst_count", hs_run, 4);

    // modular reduction lanes 3328,3329,4095,0
    addr_q.push_back(7'd40);
`ifdef KYBER_COEF_REDUCE_EN
    exp_q.push_back(13'd3328); exp_q.push_back(13'd0);
    exp_q.push_back(13'd766);  exp_q.push_back({1'b1, 12'd0});
`else
    exp_q.push_back(13'd3328); exp_q.push_back(13'd3329);
    exp_q.push_back(13'd4095); exp_q.push_back({1'b1, 12'd0});
`endif
    start_only(40, 1);
    wait_idle("reduce_timeout");
    chk("reduce_count", hs_run, 4);

    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
